// File: rtl/cm138_pkg.sv
// Shared types, sizes and bit-vector helpers for the cm138 line encoder.
package cm138_pkg;

  localparam int LINES  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when two or more bits of the vector are set.
  function automatic logic multi_bits(input logic [LINES-1:0] v);
    return (v & (v - {{(LINES-1){1'b0}}, 1'b1})) != {LINES{1'b0}};
  endfunction

  // True when exactly one bit of the vector is set.
  function automatic logic one_hot(input logic [LINES-1:0] v);
    return (v != {LINES{1'b0}}) && !multi_bits(v);
  endfunction

endpackage

// File: rtl/cm138_encoder_if.sv
// Request/handshake bundle between the encoder and its requesters/consumer.
interface cm138_encoder_if;
  import cm138_pkg::*;

  logic [LINES-1:0]  req_n;
  logic              en;
  logic [1:0]        en_n;
  logic              ready;
  logic [CODE_W-1:0] code;
  logic              valid;
  logic              last;
  logic              multi;
  logic              busy;

  modport master (
    input  req_n, en, en_n, ready,
    output code, valid, last, multi, busy
  );

  modport slave (
    output req_n, en, en_n, ready,
    input  code, valid, last, multi, busy
  );

endinterface

// File: rtl/cm138_prio8.sv
// Highest-set-bit priority encoder over eight lines (bit 7 wins).
module cm138_prio8
  import cm138_pkg::*;
(
  input  logic [LINES-1:0]  vec,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // Resolve the highest requesting line; an empty vector maps to index 0.
  always_comb begin
    any = |vec;
    casez (vec)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/cm138_encoder.sv
// Snapshot-and-drain encoder: captures the active-low request lines once,
// then presents each requesting line highest-first over a valid/ready
// handshake. New requests are only looked at again from IDLE.
module cm138_encoder
  import cm138_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  cm138_encoder_if.master bus
);

  state_t            state, state_nxt;
  logic [LINES-1:0]  pend, pend_nxt;
  logic              multi_q, multi_nxt;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              last_q;
  logic              qualify;
  logic [CODE_W-1:0] nxt_idx;
  logic              nxt_any;

  // Outputs are computed from the next pending set so they can be registered
  // and still appear in the cycle right after the capture/handshake edge.
  cm138_prio8 u_prio (
    .vec (pend_nxt),
    .idx (nxt_idx),
    .any (nxt_any)
  );

  // Next-state logic: capture in IDLE, clear the presented bit on handshake.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    multi_nxt = multi_q;
    qualify   = bus.en && (bus.en_n == 2'b00) && (bus.req_n != 8'hFF);
    case (state)
      IDLE: begin
        if (qualify) begin
          pend_nxt  = ~bus.req_n;
          state_nxt = EMIT;
          multi_nxt = multi_bits(~bus.req_n);
        end else begin
          state_nxt = IDLE;
        end
      end
      EMIT: begin
        if (bus.ready) begin
          pend_nxt = pend & ~(8'd1 << code_q);
          if (last_q) begin
            state_nxt = IDLE;
            multi_nxt = 1'b0;
          end else begin
            state_nxt = EMIT;
          end
        end else begin
          state_nxt = EMIT;
        end
      end
      default: begin
        state_nxt = IDLE;
        pend_nxt  = {LINES{1'b0}};
        multi_nxt = 1'b0;
      end
    endcase
  end

  // State, snapshot and registered outputs; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend    <= {LINES{1'b0}};
      multi_q <= 1'b0;
      code_q  <= {CODE_W{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pend    <= pend_nxt;
      multi_q <= multi_nxt;
      valid_q <= (state_nxt == EMIT);
      code_q  <= ((state_nxt == EMIT) && nxt_any) ? nxt_idx : {CODE_W{1'b0}};
      last_q  <= (state_nxt == EMIT) && one_hot(pend_nxt);
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.last  = last_q;
  assign bus.multi = multi_q;
  assign bus.busy  = valid_q;

endmodule
